writeback_arb: RTL and testbench

WRITEBACK_ARB -- requirements
Module: writeback_arb

---
 rtl/writeback_arb.sv | 192 +++++++++++++++++++
 tb/tb_writeback_arb.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arb.sv
// Writeback arbiter: three per-source result FIFOs merged onto a single CDB by round-robin,
// with mispredict flush that drops entries younger than the branch and compacts each queue.
module writeback_arb #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             alu_valid,
  input  logic [TAG_W-1:0] alu_rob_tag,
  input  logic [6:0]       alu_pd,
  input  logic             alu_has_dest,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,

  input  logic             b_valid,
  input  logic [TAG_W-1:0] b_rob_tag,
  input  logic [6:0]       b_pd,
  input  logic             b_has_dest,
  input  logic [31:0]      b_data,
  output logic             b_ready,

  input  logic             mem_valid,
  input  logic [TAG_W-1:0] mem_rob_tag,
  input  logic [6:0]       mem_pd,
  input  logic             mem_has_dest,
  input  logic [31:0]      mem_data,
  output logic             mem_ready,

  input  logic [TAG_W-1:0] rob_head,
  input  logic             mispredict,
  input  logic [TAG_W-1:0] mispredict_tag,

  output logic             cdb_valid,
  output logic [TAG_W-1:0] cdb_rob_tag,
  output logic [6:0]       cdb_pd,
  output logic [31:0]      cdb_data,
  output logic             cdb_we,
  output logic [1:0]       cdb_src
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int NSRC = 3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [6:0]       pd;
    logic             has_dest;
    logic [31:0]      data;
  } entry_t;

  entry_t        r_q   [NSRC][DEPTH];
  logic [PW-1:0] r_rd  [NSRC];
  logic [CW-1:0] r_cnt [NSRC];
  logic [1:0]    r_rr;
  entry_t        r_cdb;
  logic          r_cdb_valid;
  logic          r_cdb_we;
  logic [1:0]    r_cdb_src;

  entry_t        w_in    [NSRC];
  logic          w_vin   [NSRC];
  logic          w_ready [NSRC];
  entry_t        w_head  [NSRC];
  logic          w_elig  [NSRC];
  logic          w_push  [NSRC];
  logic          w_pop   [NSRC];
  entry_t        w_nq    [NSRC][DEPTH];
  logic [PW-1:0] w_nrd   [NSRC];
  logic [CW-1:0] w_ncnt  [NSRC];
  int unsigned   w_j;
  logic [2:0]    w_sum;
  logic [1:0]    w_cand;
  logic          w_gnt_valid;
  logic [1:0]    w_gnt_src;
  entry_t        w_gnt_entry;
  logic          w_cdb_kill;

  // Ages are measured from the ROB head so tag wrap-around compares correctly.
  function automatic logic f_younger(input logic [TAG_W-1:0] t, input logic [TAG_W-1:0] h,
                                     input logic [TAG_W-1:0] m);
    logic [TAG_W-1:0] age_t;
    logic [TAG_W-1:0] age_m;
    age_t = t - h;
    age_m = m - h;
    return age_t > age_m;
  endfunction

  assign w_in[0]  = {alu_rob_tag, alu_pd, alu_has_dest, alu_data};
  assign w_in[1]  = {b_rob_tag, b_pd, b_has_dest, b_data};
  assign w_in[2]  = {mem_rob_tag, mem_pd, mem_has_dest, mem_data};
  assign w_vin[0] = alu_valid;
  assign w_vin[1] = b_valid;
  assign w_vin[2] = mem_valid;

  always_comb begin
    for (int s = 0; s < NSRC; s++) begin
      w_ready[s] = r_cnt[s] < CW'(DEPTH);
      w_head[s]  = r_q[s][r_rd[s]];
      w_elig[s]  = (r_cnt[s] != '0) &&
                   !(mispredict && f_younger(w_head[s].tag, rob_head, mispredict_tag));
      w_push[s]  = w_vin[s] && w_ready[s] &&
                   !(mispredict && f_younger(w_in[s].tag, rob_head, mispredict_tag));
    end
  end

  // Search order starts at r_rr, which points just past the last granted source.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_src   = r_rr;
    w_gnt_entry = w_head[0];
    w_sum       = '0;
    w_cand      = '0;
    for (int k = 0; k < NSRC; k++) begin
      w_sum = {1'b0, r_rr} + 3'(k);
      if (w_sum >= 3'd3) begin
        w_sum = w_sum - 3'd3;
      end
      w_cand = w_sum[1:0];
      if (!w_gnt_valid && w_elig[w_cand]) begin
        w_gnt_valid = 1'b1;
        w_gnt_src   = w_cand;
        w_gnt_entry = w_head[w_cand];
      end
    end
  end

  // Survivors are repacked from the new read pointer; with no flush each stays in place.
  always_comb begin
    w_j = 0;
    for (int s = 0; s < NSRC; s++) begin
      w_nq[s]  = r_q[s];
      w_pop[s] = w_gnt_valid && (w_gnt_src == 2'(s));
      w_nrd[s] = r_rd[s] + PW'(w_pop[s]);
      w_j      = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if ((CW'(i) < r_cnt[s]) && !(i == 0 && w_pop[s]) &&
            !(mispredict && f_younger(r_q[s][r_rd[s] + PW'(i)].tag, rob_head,
                                      mispredict_tag))) begin
          w_nq[s][w_nrd[s] + PW'(w_j)] = r_q[s][r_rd[s] + PW'(i)];
          w_j = w_j + 1;
        end
      end
      if (w_push[s]) begin
        w_nq[s][w_nrd[s] + PW'(w_j)] = w_in[s];
        w_j = w_j + 1;
      end
      w_ncnt[s] = CW'(w_j);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < NSRC; s++) begin
        r_rd[s]  <= '0;
        r_cnt[s] <= '0;
      end
      r_rr        <= 2'd0;
      r_cdb       <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_we    <= 1'b0;
      r_cdb_src   <= 2'd0;
    end else begin
      r_q         <= w_nq;
      r_rd        <= w_nrd;
      r_cnt       <= w_ncnt;
      r_cdb_valid <= w_gnt_valid;
      r_cdb_we    <= w_gnt_valid && w_gnt_entry.has_dest && (w_gnt_entry.pd != 7'd0);
      if (w_gnt_valid) begin
        r_cdb     <= w_gnt_entry;
        r_cdb_src <= w_gnt_src;
        r_rr      <= (w_gnt_src == 2'd2) ? 2'd0 : w_gnt_src + 2'd1;
      end
    end
  end

  // A broadcast already registered can still be squashed by a mispredict in its own cycle.
  assign w_cdb_kill  = mispredict && f_younger(r_cdb.tag, rob_head, mispredict_tag);

  assign alu_ready   = w_ready[0];
  assign b_ready     = w_ready[1];
  assign mem_ready   = w_ready[2];
  assign cdb_valid   = r_cdb_valid && !w_cdb_kill;
  assign cdb_we      = r_cdb_we && !w_cdb_kill;
  assign cdb_rob_tag = r_cdb.tag;
  assign cdb_pd      = r_cdb.pd;
  assign cdb_data    = r_cdb.data;
  assign cdb_src     = r_cdb_src;

endmodule

// File: tb/tb_writeback_arb.sv
// Bench for writeback_arb: directed vector table plus multi-cycle sequences, with a
// per-source scoreboard checking every CDB broadcast.
module tb_writeback_arb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        v   [3];
  logic [4:0]  tg  [3];
  logic [6:0]  pdi [3];
  logic        hd  [3];
  logic [31:0] dt  [3];
  logic        alu_ready, b_ready, mem_ready;
  logic [4:0]  rob_head, mp_tag;
  logic        mp;
  logic        cdb_valid, cdb_we;
  logic [4:0]  cdb_rob_tag;
  logic [6:0]  cdb_pd;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int n_checks = 0;
  int n_fail   = 0;
  int alu_bc   = 0;
  bit acc [3];

  typedef struct {
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  typedef struct {
    int          src;
    logic [4:0]  tag;
    logic [6:0]  pd;
    logic        hd;
    logic [31:0] data;
    logic        we;
  } vec_t;

  vec_t vt [6];

  writeback_arb #(.DEPTH(2), .TAG_W(5)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_valid     (v[0]),
    .alu_rob_tag   (tg[0]),
    .alu_pd        (pdi[0]),
    .alu_has_dest  (hd[0]),
    .alu_data      (dt[0]),
    .alu_ready     (alu_ready),
    .b_valid       (v[1]),
    .b_rob_tag     (tg[1]),
    .b_pd          (pdi[1]),
    .b_has_dest    (hd[1]),
    .b_data        (dt[1]),
    .b_ready       (b_ready),
    .mem_valid     (v[2]),
    .mem_rob_tag   (tg[2]),
    .mem_pd        (pdi[2]),
    .mem_has_dest  (hd[2]),
    .mem_data      (dt[2]),
    .mem_ready     (mem_ready),
    .rob_head      (rob_head),
    .mispredict    (mp),
    .mispredict_tag(mp_tag),
    .cdb_valid     (cdb_valid),
    .cdb_rob_tag   (cdb_rob_tag),
    .cdb_pd        (cdb_pd),
    .cdb_data      (cdb_data),
    .cdb_we        (cdb_we),
    .cdb_src       (cdb_src)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic bit younger(input logic [4:0] t, input logic [4:0] m);
    logic [4:0] at;
    logic [4:0] am;
    at = t - rob_head;
    am = m - rob_head;
    return at > am;
  endfunction

  function automatic logic rdy_of(input int s);
    case (s)
      0:       return alu_ready;
      1:       return b_ready;
      default: return mem_ready;
    endcase
  endfunction

  function automatic int sb_size();
    return q0.size() + q1.size() + q2.size();
  endfunction

  task automatic push_exp(input int s, input exp_t e);
    case (s)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic flush_exp();
    for (int i = q0.size() - 1; i >= 0; i--) if (younger(q0[i].tag, mp_tag)) q0.delete(i);
    for (int i = q1.size() - 1; i >= 0; i--) if (younger(q1[i].tag, mp_tag)) q1.delete(i);
    for (int i = q2.size() - 1; i >= 0; i--) if (younger(q2[i].tag, mp_tag)) q2.delete(i);
  endtask

  // Scoreboard consumer: every visible broadcast must match the oldest expected entry.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    if (cdb_valid === 1'b1) begin
      have = 1'b0;
      case (cdb_src)
        2'd0: if (q0.size() != 0) begin e = q0.pop_front(); have = 1'b1; alu_bc++; end
        2'd1: if (q1.size() != 0) begin e = q1.pop_front(); have = 1'b1; end
        2'd2: if (q2.size() != 0) begin e = q2.pop_front(); have = 1'b1; end
        default: have = 1'b0;
      endcase
      n_checks++;
      if (!have) begin
        n_fail++;
        $display("FAIL sb_unexpected: got src %0d tag %0d, required no broadcast",
                 cdb_src, cdb_rob_tag);
      end else if ({cdb_rob_tag, cdb_pd, cdb_data, cdb_we} !== {e.tag, e.pd, e.data, e.we}) begin
        n_fail++;
        $display("FAIL sb_entry: got tag %0d pd %0d data %0h we %0b, required %0d %0d %0h %0b",
                 cdb_rob_tag, cdb_pd, cdb_data, cdb_we, e.tag, e.pd, e.data, e.we);
      end
    end
  end

  // One clock: model acceptance/flush at the falling edge, then step past the rising edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    #1;
    for (int s = 0; s < 3; s++) acc[s] = 1'b0;
    if (!reset) begin
      if (mp) flush_exp();
      for (int s = 0; s < 3; s++) begin
        if (v[s] && rdy_of(s) && !(mp && younger(tg[s], mp_tag))) begin
          acc[s] = 1'b1;
          e.tag  = tg[s];
          e.pd   = pdi[s];
          e.data = dt[s];
          e.we   = hd[s] && (pdi[s] != 7'd0);
          push_exp(s, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < 3; s++) begin
      v[s] = 1'b0; tg[s] = '0; pdi[s] = '0; hd[s] = 1'b0; dt[s] = '0;
    end
    mp     = 1'b0;
    mp_tag = '0;
  endtask

  task automatic set_src(input int s, input logic [4:0] t, input logic [6:0] p, input logic h,
                         input logic [31:0] d);
    v[s] = 1'b1; tg[s] = t; pdi[s] = p; hd[s] = h; dt[s] = d;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    alu_bc = 0;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    clear_inputs();
    while (sb_size() != 0 && k < 50) begin
      cycle();
      k++;
    end
    cycle();
    cycle();
    check(name, 64'(sb_size()), 64'd0);
  endtask

  initial begin
    int  ai, bi, mi;
    bit  saw_low;

    vt[0] = '{0, 5'd3,  7'd9,   1'b1, 32'h0000DEAD, 1'b1};
    vt[1] = '{1, 5'd7,  7'd12,  1'b1, 32'h12345678, 1'b1};
    vt[2] = '{2, 5'd20, 7'd0,   1'b1, 32'hCAFEF00D, 1'b0};
    vt[3] = '{0, 5'd31, 7'd5,   1'b0, 32'h00000001, 1'b0};
    vt[4] = '{2, 5'd0,  7'd127, 1'b1, 32'hFFFFFFFF, 1'b1};
    vt[5] = '{1, 5'd16, 7'd64,  1'b1, 32'h80000000, 1'b1};

    rob_head = '0;
    clear_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("rst_cdb_we", 64'(cdb_we), 64'd0);
    check("rst_cdb_fields", {cdb_rob_tag, cdb_pd, cdb_data, cdb_src}, 64'd0);
    check("rst_ready", {alu_ready, b_ready, mem_ready}, 64'b111);

    // Single uncontended transactions: visible exactly one cycle, two edges after capture.
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      set_src(vt[i].src, vt[i].tag, vt[i].pd, vt[i].hd, vt[i].data);
      cycle();
      clear_inputs();
      check($sformatf("vec%0d_early", i), 64'(cdb_valid), 64'd0);
      cycle();
      check($sformatf("vec%0d_valid", i), 64'(cdb_valid), 64'd1);
      check($sformatf("vec%0d_fields", i), {cdb_rob_tag, cdb_pd, cdb_data},
            {vt[i].tag, vt[i].pd, vt[i].data});
      check($sformatf("vec%0d_we", i), 64'(cdb_we), 64'(vt[i].we));
      check($sformatf("vec%0d_src", i), 64'(cdb_src), 64'(vt[i].src));
      cycle();
      check($sformatf("vec%0d_once", i), 64'(cdb_valid), 64'd0);
    end

    // Three-way contention: alu, b, mem order, then pointer is back at alu.
    do_reset();
    set_src(0, 5'd1, 7'd1, 1'b1, 32'hA1);
    set_src(1, 5'd2, 7'd2, 1'b1, 32'hB2);
    set_src(2, 5'd3, 7'd3, 1'b1, 32'hC3);
    cycle();
    clear_inputs();
    cycle();
    check("rr_first", {cdb_valid, cdb_src, cdb_rob_tag}, {1'b1, 2'd0, 5'd1});
    cycle();
    check("rr_second", {cdb_valid, cdb_src, cdb_rob_tag}, {1'b1, 2'd1, 5'd2});
    cycle();
    check("rr_third", {cdb_valid, cdb_src, cdb_rob_tag}, {1'b1, 2'd2, 5'd3});
    set_src(0, 5'd4, 7'd4, 1'b1, 32'hA4);
    set_src(1, 5'd5, 7'd5, 1'b1, 32'hB5);
    set_src(2, 5'd6, 7'd6, 1'b1, 32'hC6);
    cycle();
    clear_inputs();
    cycle();
    check("rr_wrap_alu", {cdb_valid, cdb_src, cdb_rob_tag}, {1'b1, 2'd0, 5'd4});
    drain("drain_rr");

    // Backpressure: alu held valid while b/mem keep the CDB busy.
    do_reset();
    ai = 0; bi = 0; mi = 0; saw_low = 1'b0;
    for (int c = 0; c < 60 && (ai < 4 || bi < 8 || mi < 8); c++) begin
      if (ai < 4) set_src(0, 5'(8 + ai), 7'(1 + ai), 1'b1, 32'(100 + ai)); else v[0] = 1'b0;
      if (bi < 8) set_src(1, 5'(12 + bi), 7'(10 + bi), 1'b1, 32'(200 + bi)); else v[1] = 1'b0;
      if (mi < 8) set_src(2, 5'(20 + mi), 7'(30 + mi), 1'b1, 32'(300 + mi)); else v[2] = 1'b0;
      cycle();
      if (acc[0]) ai++;
      if (acc[1]) bi++;
      if (acc[2]) mi++;
      if (!alu_ready && !saw_low) begin
        saw_low = 1'b1;
        check("alu_full_at_depth", 64'(ai - alu_bc), 64'd2);
      end
    end
    check("alu_ready_went_low", 64'(saw_low), 64'd1);
    check("all_accepted", {32'(ai), 32'(bi + mi)}, {32'd4, 32'd16});
    drain("drain_contended");

    // Flush with head near wrap: 31 survives, 1 and 4 dropped; same-cycle push filtered by age.
    do_reset();
    rob_head = 5'd30;
    set_src(0, 5'd31, 7'd11, 1'b1, 32'h31);
    set_src(1, 5'd1, 7'd12, 1'b1, 32'h01);
    set_src(2, 5'd4, 7'd13, 1'b1, 32'h04);
    cycle();
    clear_inputs();
    mp     = 1'b1;
    mp_tag = 5'd0;
    set_src(1, 5'd2, 7'd14, 1'b1, 32'h02);
    set_src(2, 5'd30, 7'd15, 1'b1, 32'h30);
    cycle();
    clear_inputs();
    check("flush_keep_31", {cdb_valid, cdb_src, cdb_rob_tag, cdb_we}, {1'b1, 2'd0, 5'd31, 1'b1});
    cycle();
    check("flush_older_push", {cdb_valid, cdb_src, cdb_rob_tag}, {1'b1, 2'd2, 5'd30});
    check("flush_ready", {alu_ready, b_ready, mem_ready}, 64'b111);
    cycle();
    check("flush_dropped", 64'(cdb_valid), 64'd0);
    drain("drain_flush");
    rob_head = 5'd0;

    // Registered broadcast squashed by a mispredict arriving in its display cycle.
    do_reset();
    set_src(0, 5'd5, 7'd21, 1'b1, 32'h55);
    cycle();
    clear_inputs();
    cycle();
    mp     = 1'b1;
    mp_tag = 5'd2;
    #1;
    check("squash_valid_we", {cdb_valid, cdb_we}, 64'd0);
    cycle();
    clear_inputs();
    check("squash_gone", 64'(cdb_valid), 64'd0);
    drain("drain_squash");

    // Reset with loaded queues; input offered during reset must be discarded.
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_src(0, 5'(c), 7'(40 + c), 1'b1, 32'(400 + c));
      set_src(1, 5'(8 + c), 7'(50 + c), 1'b1, 32'(500 + c));
      set_src(2, 5'(16 + c), 7'(60 + c), 1'b1, 32'(600 + c));
      cycle();
    end
    check("loaded_not_ready", 64'(alu_ready && b_ready && mem_ready), 64'd0);
    reset = 1'b1;
    v[1] = 1'b0;
    v[2] = 1'b0;
    set_src(0, 5'd9, 7'd9, 1'b1, 32'h99);
    cycle();
    reset = 1'b0;
    clear_inputs();
    q0.delete(); q1.delete(); q2.delete();
    check("post_rst_ready", {alu_ready, b_ready, mem_ready}, 64'b111);
    check("post_rst_cdb", {cdb_valid, cdb_we}, 64'd0);
    for (int c = 0; c < 4; c++) begin
      cycle();
      check($sformatf("post_rst_idle%0d", c), 64'(cdb_valid), 64'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
